dbg_read_port: RTL and testbench

Debug readout responder inside Top: serves the external `address`/`value_o` observation pins by fetching the addressed word from the register file, data memory or CGRA CSR bank, and presents it stably on `value_o`. It is the target side of the bench's register/memory dump sweep. It uses a dedicated register-file read port and the shared data-memory port, where the CPU has priority.

---
 rtl/dbg_pkg.sv | 28 ++
 rtl/dbg_addr_decode.sv | 37 +++
 rtl/dbg_read_port.sv | 216 +++++++++++++++++++++
 tb/tb_dbg_read_port.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug readout responder: address map,
// error pattern, FSM state and decoded-region encodings.
package dbg_pkg;

    localparam int DM_BASE   = 32;
    localparam int DM_WORDS  = 256;
    localparam int CSR_BASE  = 288;
    localparam int CSR_WORDS = 16;

    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RF_RD,
        S_CSR_RD,
        S_DM_REQ,
        S_DM_WAIT,
        S_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        RGN_RF,
        RGN_DM,
        RGN_CSR,
        RGN_NONE
    } region_t;

endpackage

// File: rtl/dbg_addr_decode.sv
// Combinational decode of the registered debug address into a region
// and the word index local to that region.
module dbg_addr_decode
    import dbg_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DM_BASE   = dbg_pkg::DM_BASE,
    parameter int DM_WORDS  = dbg_pkg::DM_WORDS,
    parameter int CSR_BASE  = dbg_pkg::CSR_BASE,
    parameter int CSR_WORDS = dbg_pkg::CSR_WORDS
) (
    input  logic [ADDR_W-1:0] addr,
    output region_t           region,
    output logic [7:0]        idx
);

    logic [31:0] a32;

    // Region compare on a zero-extended copy; the index only needs the
    // low byte of the offset, so subtract in 8 bits.
    always_comb begin
        a32    = 32'(addr);
        region = RGN_NONE;
        idx    = '0;
        if (a32 < 32'(DM_BASE)) begin
            region = RGN_RF;
            idx    = addr[7:0];
        end else if (a32 < 32'(DM_BASE + DM_WORDS)) begin
            region = RGN_DM;
            idx    = addr[7:0] - 8'(DM_BASE);
        end else if ((a32 >= 32'(CSR_BASE)) && (a32 < 32'(CSR_BASE + CSR_WORDS))) begin
            region = RGN_CSR;
            idx    = addr[7:0] - 8'(CSR_BASE);
        end
    end

endmodule

// File: rtl/dbg_read_port.sv
// Debug readout responder: fetches the word at the external address from
// the register file, data memory or CGRA CSR bank and holds it on value_o.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | result held; decode a new address when it appears
//   S_RF_RD   | register-file read port driven, capture next edge
//   S_CSR_RD  | CSR index driven, capture next edge
//   S_DM_REQ  | dm_req high until grant; timeout down-counter running
//   S_DM_WAIT | granted, waiting for the dm_rvalid beat
//   S_DRAIN   | address moved after grant; swallow the beat, then restart
module dbg_read_port
    import dbg_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int DM_BASE   = dbg_pkg::DM_BASE,
    parameter int DM_WORDS  = dbg_pkg::DM_WORDS,
    parameter int CSR_BASE  = dbg_pkg::CSR_BASE,
    parameter int CSR_WORDS = dbg_pkg::CSR_WORDS,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] value_o,
    output logic              value_valid_o,
    output logic              err_o,
    output logic [4:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dm_req,
    output logic [7:0]        dm_addr,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [3:0]        csr_raddr,
    input  logic [DATA_W-1:0] csr_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(DEAD_BEEF);

    state_t            state, state_nx;
    region_t           rgn;
    logic [7:0]        rgn_idx;

    logic [ADDR_W-1:0] addr_q, addr_prev;
    logic              force_q;
    logic [7:0]        idx_q;
    logic [CNT_W-1:0]  wait_left;
    logic              beat_seen;
    logic [DATA_W-1:0] value_q;
    logic              valid_q;
    logic              err_q;

    logic              new_lookup;
    logic              do_decode;
    logic              ld_val;
    logic [DATA_W-1:0] ld_data;
    logic              set_err;
    logic              cnt_dec;
    logic              mark_beat;

    dbg_addr_decode #(
        .ADDR_W    (ADDR_W),
        .DM_BASE   (DM_BASE),
        .DM_WORDS  (DM_WORDS),
        .CSR_BASE  (CSR_BASE),
        .CSR_WORDS (CSR_WORDS)
    ) u_decode (
        .addr   (addr_q),
        .region (rgn),
        .idx    (rgn_idx)
    );

    // force_q makes the post-reset lookup of address 0 happen even though
    // addr_q and addr_prev both come out of reset equal.
    assign new_lookup = force_q | (addr_q != addr_prev);

    // Read-side addresses come from the index latched at lookup start so
    // they stay stable even while addr_q is moving.
    assign rf_raddr      = idx_q[4:0];
    assign csr_raddr     = idx_q[3:0];
    assign dm_addr       = idx_q;
    assign value_o       = value_q;
    assign value_valid_o = valid_q & ~new_lookup;
    assign err_o         = err_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and control; an address change outside DM_WAIT/DRAIN
    // re-decodes directly, so dm_req drops for exactly that one cycle.
    always_comb begin
        state_nx  = state;
        do_decode = 1'b0;
        ld_val    = 1'b0;
        ld_data   = value_q;
        set_err   = 1'b0;
        cnt_dec   = 1'b0;
        mark_beat = 1'b0;
        dm_req    = 1'b0;
        unique case (state)
            S_IDLE: begin
                do_decode = new_lookup;
            end
            S_RF_RD: begin
                if (new_lookup) begin
                    do_decode = 1'b1;
                end else begin
                    ld_val   = 1'b1;
                    ld_data  = rf_rdata;
                    state_nx = S_IDLE;
                end
            end
            S_CSR_RD: begin
                if (new_lookup) begin
                    do_decode = 1'b1;
                end else begin
                    ld_val   = 1'b1;
                    ld_data  = csr_rdata;
                    state_nx = S_IDLE;
                end
            end
            S_DM_REQ: begin
                if (new_lookup) begin
                    do_decode = 1'b1;
                end else if (wait_left == '0) begin
                    ld_val   = 1'b1;
                    ld_data  = ERR_WORD;
                    set_err  = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    dm_req = 1'b1;
                    if (dm_gnt) begin
                        state_nx = S_DM_WAIT;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            S_DM_WAIT: begin
                if (new_lookup) begin
                    mark_beat = dm_rvalid;
                    state_nx  = S_DRAIN;
                end else if (dm_rvalid) begin
                    ld_val   = 1'b1;
                    ld_data  = dm_rdata;
                    state_nx = S_IDLE;
                end
            end
            S_DRAIN: begin
                do_decode = beat_seen | dm_rvalid;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (do_decode) begin
            unique case (rgn)
                RGN_RF:  state_nx = S_RF_RD;
                RGN_DM:  state_nx = S_DM_REQ;
                RGN_CSR: state_nx = S_CSR_RD;
                default: begin
                    state_nx = S_IDLE;
                    ld_val   = 1'b1;
                    ld_data  = ERR_WORD;
                    set_err  = 1'b1;
                end
            endcase
        end
    end

    // Address pipeline, lookup bookkeeping and the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            addr_prev <= '0;
            force_q   <= 1'b1;
            idx_q     <= '0;
            wait_left <= '0;
            beat_seen <= 1'b0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            addr_q    <= address;
            addr_prev <= addr_q;
            force_q   <= 1'b0;
            beat_seen <= mark_beat;
            if (do_decode) begin
                idx_q     <= rgn_idx;
                wait_left <= CNT_W'(TIMEOUT);
            end else if (cnt_dec) begin
                wait_left <= wait_left - 1'b1;
            end
            if (ld_val) begin
                value_q <= ld_data;
                valid_q <= 1'b1;
            end else if (new_lookup) begin
                valid_q <= 1'b0;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dbg_read_port.sv
// Directed bench for dbg_read_port with small RF/CSR/DM models and a
// stall-programmable data-memory arbiter.
module tb_dbg_read_port;
    import dbg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  address;
    logic [31:0] value_o;
    logic        value_valid_o;
    logic        err_o;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        dm_req;
    logic [7:0]  dm_addr;
    logic        dm_gnt;
    logic        dm_rvalid = 1'b0;
    logic [31:0] dm_rdata  = '0;
    logic [3:0]  csr_raddr;
    logic [31:0] csr_rdata;

    logic [31:0] rf_mem  [32];
    logic [31:0] csr_mem [16];
    logic [31:0] dm_mem  [256];

    logic        gnt_en     = 1'b1;
    int          stall_cfg  = 0;
    int          stall_seen = 0;

    int n_cmp = 0;
    int n_err = 0;

    dbg_read_port dut (
        .clk           (clk),
        .rst           (rst),
        .address       (address),
        .value_o       (value_o),
        .value_valid_o (value_valid_o),
        .err_o         (err_o),
        .rf_raddr      (rf_raddr),
        .rf_rdata      (rf_rdata),
        .dm_req        (dm_req),
        .dm_addr       (dm_addr),
        .dm_gnt        (dm_gnt),
        .dm_rvalid     (dm_rvalid),
        .dm_rdata      (dm_rdata),
        .csr_raddr     (csr_raddr),
        .csr_rdata     (csr_rdata)
    );

    always #5 clk = ~clk;

    assign rf_rdata  = rf_mem[rf_raddr];
    assign csr_rdata = csr_mem[csr_raddr];
    assign dm_gnt    = dm_req && gnt_en && (stall_seen >= stall_cfg);

    // Arbiter model: grant after stall_cfg refused cycles, data one cycle later.
    always @(posedge clk) begin
        if (dm_req && !dm_gnt) stall_seen <= stall_seen + 1;
        else                   stall_seen <= 0;
        dm_rvalid <= dm_gnt;
        dm_rdata  <= dm_mem[dm_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++)  rf_mem[i]  = 32'h1000_0000 + 32'(i * 17);
        for (int i = 0; i < 16; i++)  csr_mem[i] = 32'hC000_0000 + 32'(i);
        for (int i = 0; i < 256; i++) dm_mem[i]  = 32'h5500_0000 + 32'(i);
        rf_mem[5]    = 32'h0000_00A5;
        rf_mem[3]    = 32'h3333_0003;
        dm_mem[10]   = 32'h1234_5678;
        dm_mem[8]    = 32'h0BAD_F00D;
        dm_mem[255]  = 32'hFFEE_0255;

        rst     = 1'b1;
        address = '0;
        tick(3);
        chk("rst_value", value_o, 32'h0);
        chk("rst_valid", 32'(value_valid_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_dm_req", 32'(dm_req), 32'h0);

        // Forced lookup of address 0 after release.
        rst = 1'b0;
        tick(2);
        chk("boot_value", value_o, rf_mem[0]);
        chk("boot_valid", 32'(value_valid_o), 32'h1);

        // RF read: sampled at N, result at N+2, stale value visible at N+1.
        address = 10'd5;
        tick(2);
        chk("rf_valid_drop", 32'(value_valid_o), 32'h0);
        chk("rf_stale", value_o, rf_mem[0]);
        tick(1);
        chk("rf_value", value_o, 32'h0000_00A5);
        chk("rf_valid", 32'(value_valid_o), 32'h1);

        // DM read with a 3-cycle grant stall: result at N+6.
        stall_cfg = 3;
        address   = 10'd42;
        tick(2);
        chk("dm_req_up", 32'(dm_req), 32'h1);
        chk("dm_addr", 32'(dm_addr), 32'd10);
        tick(4);
        chk("dm_wait_valid", 32'(value_valid_o), 32'h0);
        chk("dm_wait_req", 32'(dm_req), 32'h0);
        tick(1);
        chk("dm_value", value_o, 32'h1234_5678);
        chk("dm_valid", 32'(value_valid_o), 32'h1);
        stall_cfg = 0;

        // CSR read.
        address = 10'd290;
        tick(3);
        chk("csr_value", value_o, csr_mem[2]);
        chk("csr_valid", 32'(value_valid_o), 32'h1);

        // Timeout: 15 requesting cycles, req low, result TIMEOUT+1 after rise.
        gnt_en  = 1'b0;
        address = 10'd40;
        tick(2);
        chk("to_req_up", 32'(dm_req), 32'h1);
        tick(14);
        chk("to_req_last", 32'(dm_req), 32'h1);
        chk("to_err_before", 32'(err_o), 32'h0);
        tick(1);
        chk("to_req_drop", 32'(dm_req), 32'h0);
        chk("to_valid_before", 32'(value_valid_o), 32'h0);
        tick(1);
        chk("to_value", value_o, 32'hDEAD_BEEF);
        chk("to_err", 32'(err_o), 32'h1);
        chk("to_valid", 32'(value_valid_o), 32'h1);
        gnt_en = 1'b1;

        // Last DM word, immediate grant: result at N+3.
        address = 10'd287;
        tick(2);
        chk("dm_top_addr", 32'(dm_addr), 32'd255);
        chk("dm_top_req", 32'(dm_req), 32'h1);
        tick(2);
        chk("dm_top_value", value_o, 32'hFFEE_0255);

        // Unmapped address: no request, error word.
        address = 10'd1000;
        tick(1);
        chk("um_req_n", 32'(dm_req), 32'h0);
        tick(1);
        chk("um_req_n1", 32'(dm_req), 32'h0);
        tick(1);
        chk("um_value", value_o, 32'hDEAD_BEEF);
        chk("um_valid", 32'(value_valid_o), 32'h1);
        chk("um_err", 32'(err_o), 32'h1);

        // CSR bank edges: first CSR mapped, one past last unmapped.
        address = 10'd288;
        tick(3);
        chk("csr_first", value_o, csr_mem[0]);
        address = 10'd304;
        tick(3);
        chk("csr_past_end", value_o, 32'hDEAD_BEEF);
        chk("csr_past_valid", 32'(value_valid_o), 32'h1);

        // Address change while in DM_WAIT: beat dropped, RF[3] returned.
        address = 10'd40;
        tick(2);
        address = 10'd3;
        tick(1);
        chk("mid_valid_n2", 32'(value_valid_o), 32'h0);
        chk("mid_req_n2", 32'(dm_req), 32'h0);
        tick(1);
        chk("mid_valid_n3", 32'(value_valid_o), 32'h0);
        tick(1);
        chk("mid_valid_n4", 32'(value_valid_o), 32'h0);
        chk("mid_stale", value_o, 32'hDEAD_BEEF);
        tick(1);
        chk("mid_value", value_o, 32'h3333_0003);
        chk("mid_valid", 32'(value_valid_o), 32'h1);

        // Sweep 0..31 one per cycle, then hold.
        for (int i = 0; i < 32; i++) begin
            address = 10'(i);
            tick(1);
        end
        tick(3);
        chk("sweep_value", value_o, rf_mem[31]);
        chk("sweep_valid", 32'(value_valid_o), 32'h1);

        // Second sweep into DM space, reset while a request is pending.
        stall_cfg = 4;
        for (int i = 30; i <= 40; i++) begin
            address = 10'(i);
            tick(1);
        end
        tick(1);
        chk("pre_rst_req", 32'(dm_req), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_value", value_o, 32'h0);
        chk("mid_rst_valid", 32'(value_valid_o), 32'h0);
        chk("mid_rst_err", 32'(err_o), 32'h0);
        chk("mid_rst_req", 32'(dm_req), 32'h0);
        address   = '0;
        stall_cfg = 0;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("post_rst_value", value_o, rf_mem[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
